// File: rtl/game_timer_ctrl_if.sv
// rtl/game_timer_ctrl_if.sv - control inputs and run/time status of the game timer
interface game_timer_ctrl_if #(
    parameter int TIME_W = 11
);
    logic              start;
    logic              pause_btn;
    logic              playerDied;
    logic              menuScreen;
    logic              winScreen;
    logic [TIME_W-1:0] game_time;
    logic              tick;
    logic              running;
    logic              paused;
    logic              frozen;
    logic              timeout;

    modport master (
        output start, pause_btn, playerDied, menuScreen, winScreen,
        input  game_time, tick, running, paused, frozen, timeout
    );

    modport slave (
        input  start, pause_btn, playerDied, menuScreen, winScreen,
        output game_time, tick, running, paused, frozen, timeout
    );
endinterface

// File: rtl/game_timer_ctrl.sv
// rtl/game_timer_ctrl.sv - game tick prescaler and run/pause/freeze/hold sequencer
module game_timer_ctrl #(
    parameter int CLK_HZ       = 25_000_000,
    parameter int TICK_HZ      = 10,
    parameter int TIME_W       = 11,
    parameter int MAX_TIME     = 1100,
    parameter int FREEZE_TICKS = 20
) (
    input  logic               clk,
    input  logic               reset,
    game_timer_ctrl_if.slave   bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW  = (FREEZE_TICKS > 0) ? $clog2(FREEZE_TICKS + 1) : 1;
    localparam logic [PW-1:0]     PRESC_LAST  = PW'(DIV - 1);
    localparam logic [TIME_W-1:0] TIME_MAX    = TIME_W'(MAX_TIME);
    localparam logic [FW-1:0]     FREEZE_LOAD = FW'(FREEZE_TICKS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_PAUSE  = 3'd2,
        S_FREEZE = 3'd3,
        S_HOLD   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [TIME_W-1:0] game_time_q, game_time_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [FW-1:0]     freeze_q, freeze_d;
    logic              tick_q, tick_d;
    logic              sync1_q, sync2_q, sync3_q;
    logic              pause_edge;
    logic              wrap;

    // sync3_q is the registered previous level, so only rising edges of the button count
    assign pause_edge = sync2_q & ~sync3_q;
    assign wrap       = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            game_time_q <= '0;
            presc_q     <= '0;
            freeze_q    <= '0;
            tick_q      <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            game_time_q <= game_time_d;
            presc_q     <= presc_d;
            freeze_q    <= freeze_d;
            tick_q      <= tick_d;
            sync1_q     <= bus.pause_btn;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        game_time_d = game_time_q;
        presc_d     = presc_q;
        freeze_d    = freeze_q;
        tick_d      = 1'b0;

        if (bus.menuScreen) begin
            state_d     = S_IDLE;
            game_time_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    game_time_d = '0;
                    if (bus.start) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (bus.playerDied) begin
                        state_d     = S_FREEZE;
                        game_time_d = '0;
                        presc_d     = '0;
                        freeze_d    = FREEZE_LOAD;
                    end else if (bus.winScreen) begin
                        state_d = S_HOLD;
                    end else if (pause_edge) begin
                        // prescaler keeps its value across the pause so no tick is lost or gained
                        state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
                    end else if (state_q == S_RUN) begin
                        if (wrap) begin
                            presc_d = '0;
                            if (game_time_q != TIME_MAX) begin
                                game_time_d = game_time_q + 1'b1;
                                tick_d      = 1'b1;
                            end
                            if (game_time_q + 1'b1 == TIME_MAX || game_time_q == TIME_MAX) begin
                                state_d = S_HOLD;
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
                S_FREEZE: begin
                    game_time_d = '0;
                    if (bus.winScreen) begin
                        state_d = S_HOLD;
                    end else if (freeze_q == '0) begin
                        state_d = S_RUN;
                    end else if (wrap) begin
                        presc_d  = '0;
                        freeze_d = freeze_q - 1'b1;
                        if (freeze_q == FW'(1)) begin
                            state_d = S_RUN;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                S_HOLD: begin
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.game_time = game_time_q;
    assign bus.tick      = tick_q;
    assign bus.running   = (state_q == S_RUN);
    assign bus.paused    = (state_q == S_PAUSE);
    assign bus.frozen    = (state_q == S_FREEZE);
    assign bus.timeout   = (game_time_q == TIME_MAX);
endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb/tb_game_timer_ctrl.sv - directed self-checking bench for game_timer_ctrl
module tb_game_timer_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    game_timer_ctrl_if #(.TIME_W(11)) bus ();

    game_timer_ctrl #(
        .CLK_HZ      (100),
        .TICK_HZ     (10),
        .TIME_W      (11),
        .MAX_TIME    (30),
        .FREEZE_TICKS(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [10:0] gt, input logic r,
                             input logic p, input logic f);
        chk({tag, ".game_time"}, 32'(bus.game_time), 32'(gt));
        chk({tag, ".running"},   32'(bus.running),   32'(r));
        chk({tag, ".paused"},    32'(bus.paused),    32'(p));
        chk({tag, ".frozen"},    32'(bus.frozen),    32'(f));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        bus.start      = 1'b0;
        bus.pause_btn  = 1'b0;
        bus.playerDied = 1'b0;
        bus.menuScreen = 1'b0;
        bus.winScreen  = 1'b0;

        step(2);
        chk_state("reset", 11'd0, 1'b0, 1'b0, 1'b0);
        chk("reset.tick", 32'(bus.tick), 32'd0);
        chk("reset.timeout", 32'(bus.timeout), 32'd0);
        reset = 1'b1;
        step(1);
        chk_state("idle", 11'd0, 1'b0, 1'b0, 1'b0);

        // run to saturation
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk_state("start", 11'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            step(9);
            chk("run.no_tick", 32'(bus.tick), 32'd0);
            chk("run.gt_before", 32'(bus.game_time), 32'(k - 1));
            step(1);
            chk("run.tick", 32'(bus.tick), 32'd1);
            chk("run.gt", 32'(bus.game_time), 32'(k));
        end
        chk("sat.timeout", 32'(bus.timeout), 32'd1);
        chk("sat.running", 32'(bus.running), 32'd0);
        step(50);
        chk_state("hold30", 11'd30, 1'b0, 1'b0, 1'b0);
        chk("hold30.timeout", 32'(bus.timeout), 32'd1);
        chk("hold30.tick", 32'(bus.tick), 32'd0);
        bus.menuScreen = 1'b1;
        step(1);
        bus.menuScreen = 1'b0;
        chk_state("menu_from_hold", 11'd0, 1'b0, 1'b0, 1'b0);
        chk("menu_from_hold.timeout", 32'(bus.timeout), 32'd0);

        // pause and resume at game_time 5
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(50);
        chk("pre_pause.gt", 32'(bus.game_time), 32'd5);
        bus.pause_btn = 1'b1;
        step(2);
        chk("pause.latency", 32'(bus.paused), 32'd0);
        step(1);
        chk_state("paused", 11'd5, 1'b0, 1'b1, 1'b0);
        bus.pause_btn = 1'b0;
        step(50);
        chk_state("paused_hold", 11'd5, 1'b0, 1'b1, 1'b0);
        chk("paused_hold.tick", 32'(bus.tick), 32'd0);
        bus.pause_btn = 1'b1;
        step(3);
        bus.pause_btn = 1'b0;
        chk_state("resumed", 11'd5, 1'b1, 1'b0, 1'b0);
        step(7);
        chk("resume.no_tick", 32'(bus.tick), 32'd0);
        chk("resume.gt5", 32'(bus.game_time), 32'd5);
        step(1);
        chk("resume.tick", 32'(bus.tick), 32'd1);
        chk("resume.gt6", 32'(bus.game_time), 32'd6);

        // death at game_time 12, away from a wrap
        step(60);
        chk("pre_death.gt", 32'(bus.game_time), 32'd12);
        bus.playerDied = 1'b1;
        step(1);
        bus.playerDied = 1'b0;
        chk_state("death", 11'd0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 19; c++) begin
            step(1);
            chk("freeze.frozen", 32'(bus.frozen), 32'd1);
            chk("freeze.tick", 32'(bus.tick), 32'd0);
        end
        step(1);
        chk_state("freeze_done", 11'd0, 1'b1, 1'b0, 1'b0);
        step(9);
        chk("post_freeze.no_tick", 32'(bus.tick), 32'd0);
        step(1);
        chk("post_freeze.tick", 32'(bus.tick), 32'd1);
        chk("post_freeze.gt", 32'(bus.game_time), 32'd1);

        // death on the wrap cycle; a second death during freeze must not reload
        step(9);
        bus.playerDied = 1'b1;
        step(1);
        bus.playerDied = 1'b0;
        chk_state("death_wrap", 11'd0, 1'b0, 1'b0, 1'b1);
        chk("death_wrap.tick", 32'(bus.tick), 32'd0);
        step(5);
        bus.playerDied = 1'b1;
        step(1);
        bus.playerDied = 1'b0;
        step(13);
        chk("reload.frozen", 32'(bus.frozen), 32'd1);
        step(1);
        chk_state("reload_done", 11'd0, 1'b1, 1'b0, 1'b0);

        // menu during pause
        step(30);
        chk("pre_menu.gt", 32'(bus.game_time), 32'd3);
        bus.pause_btn = 1'b1;
        step(3);
        bus.pause_btn = 1'b0;
        chk_state("menu_pause", 11'd3, 1'b0, 1'b1, 1'b0);
        step(5);
        bus.menuScreen = 1'b1;
        step(1);
        bus.menuScreen = 1'b0;
        chk_state("menu_idle", 11'd0, 1'b0, 1'b0, 1'b0);

        // win at game_time 7; start while holding is ignored
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(70);
        chk("pre_win.gt", 32'(bus.game_time), 32'd7);
        bus.winScreen = 1'b1;
        step(1);
        chk_state("win", 11'd7, 1'b0, 1'b0, 1'b0);
        step(20);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk_state("win_hold", 11'd7, 1'b0, 1'b0, 1'b0);
        chk("win_hold.timeout", 32'(bus.timeout), 32'd0);
        bus.winScreen = 1'b0;
        bus.menuScreen = 1'b1;
        step(1);
        bus.menuScreen = 1'b0;

        // reset pulse mid-run
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(25);
        chk("pre_reset.gt", 32'(bus.game_time), 32'd2);
        reset = 1'b0;
        #1;
        chk_state("async_reset", 11'd0, 1'b0, 1'b0, 1'b0);
        step(1);
        reset = 1'b1;
        step(1);
        chk_state("post_reset", 11'd0, 1'b0, 1'b0, 1'b0);
        step(20);
        chk_state("post_reset_idle", 11'd0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk_state("restart", 11'd0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
